// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg : shared types and defaults for the serial-to-parallel deserializer
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

  localparam int USR_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } usr_state_e;

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_deser.sv
// ---------------------------------------------------------------------------
// usr_deser : serial-to-parallel word assembler with hold register and overrun
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module usr_deser
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_first,
  input  logic             msb_first,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  c_last = CW'(WIDTH);

  usr_state_e       r_state, w_nxt_state;
  logic [CW-1:0]    r_cnt, w_nxt_cnt;
  logic [WIDTH-1:0] r_shreg, w_nxt_shreg;
  logic             r_order, w_nxt_order;
  logic [WIDTH-1:0] r_q_out, w_nxt_q_out;
  logic             r_q_valid, w_nxt_q_valid;
  logic             r_ovr, w_nxt_ovr;

  logic             w_start, w_take, w_ord, w_complete, w_load, w_drop;
  logic [WIDTH-1:0] w_base, w_shifted;
  logic [CW-1:0]    w_cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_order   <= 1'b1;
      r_q_out   <= '0;
      r_q_valid <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_shreg   <= w_nxt_shreg;
      r_order   <= w_nxt_order;
      r_q_out   <= w_nxt_q_out;
      r_q_valid <= w_nxt_q_valid;
      r_ovr     <= w_nxt_ovr;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_shreg   = r_shreg;
    w_nxt_order   = r_order;
    w_complete    = 1'b0;

    // A first-bit marker restarts collection from any state with a clean register
    w_start   = sin_valid & sin_first;
    w_take    = w_start | (sin_valid & (r_state == ST_COLLECT));
    w_ord     = w_start ? msb_first : r_order;
    w_base    = w_start ? '0 : r_shreg;
    w_shifted = w_ord ? {w_base[WIDTH-2:0], sin} : {sin, w_base[WIDTH-1:1]};
    w_cnt_inc = w_start ? CW'(1) : r_cnt + CW'(1);

    if (w_take) begin
      w_nxt_order = w_ord;
      w_nxt_shreg = w_shifted;
      if (w_cnt_inc == c_last) begin
        w_complete  = 1'b1;
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_state = ST_COLLECT;
        w_nxt_cnt   = w_cnt_inc;
      end
    end

    // A completed word is only dropped when the held word is not being consumed
    w_load = w_complete & (~r_q_valid | q_ready);
    w_drop = w_complete & r_q_valid & ~q_ready;

    w_nxt_q_out   = w_load ? w_shifted : r_q_out;
    w_nxt_q_valid = w_load ? 1'b1 : ((r_q_valid & q_ready) ? 1'b0 : r_q_valid);
    w_nxt_ovr     = w_drop ? 1'b1 : (clr_ovr ? 1'b0 : r_ovr);
  end

  assign q_out   = r_q_out;
  assign q_valid = r_q_valid;
  assign overrun = r_ovr;
  assign busy    = (r_state == ST_COLLECT);

endmodule : usr_deser

`default_nettype wire

// File: doc/usr_deser.md
USR_DESER -- requirements
Module: usr_deser

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 sin  input  1  serial data bit.
REQ-005 sin_valid  input  1  qualifies sin; exactly one bit accepted per cycle in which it is high.
REQ-006 sin_first  input  1  marks the qualified bit as first bit of a word; ignored unless sin_valid=1.
REQ-007 msb_first  input  1  bit order; 1 = MSB first (left-shift stream), 0 = LSB first (right-shift stream); sampled only with the first bit.
REQ-008 clr_ovr  input  1  clears the overrun flag.
REQ-009 q_out  output  WIDTH  assembled word, registered.
REQ-010 q_valid  output  1  q_out holds an unconsumed word.
REQ-011 q_ready  input  1  consumer accepts q_out when q_valid=1 and q_ready=1.
REQ-012 overrun  output  1  sticky; a completed word was dropped.
REQ-013 busy  output  1  high while a word is partially collected.

Function
REQ-014 States: IDLE, COLLECT; busy SHALL equal (state==COLLECT).
REQ-015 IDLE: sin_valid=1 and sin_first=1 -> shift bit in, latch msb_first into order register, bit count=1, go to COLLECT; sin_valid=1 without sin_first -> bit discarded, stay IDLE.
REQ-016 COLLECT: each sin_valid=1 cycle shifts one bit and increments count; cycles with sin_valid=0 hold all state (gaps of any length allowed).
REQ-017 MSB-first shift: shreg <= {shreg[WIDTH-2:0], sin}; LSB-first shift: shreg <= {sin, shreg[WIDTH-1:1]}.
REQ-018 On the edge accepting bit number WIDTH, the complete word (including that bit) SHALL load q_out, q_valid SHALL set, state returns to IDLE, count clears; q_valid visible the cycle after the last bit.
REQ-019 sin_valid=1 with sin_first=1 in COLLECT SHALL discard the partial word and restart at count=1 with the new bit and newly sampled msb_first; no output, no overrun.
REQ-020 q_valid clears on the edge where q_valid=1 and q_ready=1, unless a new word completes on the same edge.
REQ-021 Completion with q_valid=1 and q_ready=1 on the same edge: new word loads, q_valid stays 1, no overrun.
REQ-022 Completion with q_valid=1 and q_ready=0: new word dropped, q_out unchanged, overrun set.
REQ-023 overrun clears only on clr_ovr=1 or reset; if a drop and clr_ovr=1 coincide, overrun SHALL be 1 (set wins).
REQ-024 q_out SHALL not change while q_valid=1 except per REQ-021.

Reset
REQ-025 rst_n=0 at a rising edge: state=IDLE, count=0, shreg=0, q_out=0, q_valid=0, overrun=0, busy=0, order register=1 (MSB first).
REQ-026 Reset overrides all other inputs, including mid-word and with q_valid pending; the partial or pending word is lost.

Structure
REQ-027 Shared package usr_pkg SHALL hold the state enum type and USR_WIDTH_DEFAULT=8.
REQ-028 Single module; no sub-module; bit counter sized $clog2(WIDTH+1).

Verification
REQ-029 MSB-first, bits 1,0,1,0,0,1,0,1 on consecutive cycles, q_ready=1 -> q_out=8'hA5, q_valid high one cycle after 8th bit, for one cycle.
REQ-030 LSB-first, bits 1,0,1,1,0,0,0,0 with sin_valid idle gaps of 3 cycles between bits -> q_out=8'h0D; busy high throughout collection.
REQ-031 q_ready=0, two full words 8'h3C then 8'hC3 -> q_out stays 8'h3C, overrun=1; clr_ovr pulse -> overrun=0.
REQ-032 After 5 bits of a word, new sin_first with MSB-first 8'hF0 -> q_out=8'hF0, no overrun, partial word never appears.
REQ-033 rst_n=0 for one cycle after 4 bits, then full word 8'h81 -> first output 8'h81; all outputs 0 during and immediately after reset.
REQ-034 Word completes on the same edge q_valid=1 and q_ready=1 -> new word loaded, q_valid stays 1, overrun=0.
